// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Clears the register file after reset, then shares its write port
//            between two writeback requesters (round-robin) and keeps a
//            per-register pending-write scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DW   = 16,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_dest,
    input  logic [DW-1:0]   a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_dest,
    input  logic [DW-1:0]   b_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_dest,
    output logic [NREG-1:0] busy,
    output logic [AW-1:0]   rf_dest,
    output logic [DW-1:0]   rf_w_in,
    output logic            rf_w_en,
    output logic            init_done
);

    localparam logic [AW-1:0] C_LAST = AW'(NREG - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_ptr;        // 0: A wins a tie, 1: B wins a tie
    logic [NREG-1:0] r_busy;
    logic [AW-1:0]   r_rf_dest;
    logic [DW-1:0]   r_rf_w_in;
    logic            r_rf_w_en;
    logic            r_init_done;

    logic            w_run;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_accept;
    logic [AW-1:0]   w_dest;
    logic [DW-1:0]   w_data;
    logic [NREG-1:0] w_busy_next;

    assign w_run     = (r_state == ST_RUN);
    assign w_grant_a = w_run && a_valid && (!b_valid || !r_ptr);
    assign w_grant_b = w_run && b_valid && (!a_valid ||  r_ptr);
    assign w_accept  = w_grant_a || w_grant_b;
    assign w_dest    = w_grant_a ? a_dest : b_dest;
    assign w_data    = w_grant_a ? a_data : b_data;

    // Set is applied after clear so a same-edge reissue keeps the bit pending.
    always_comb begin
        w_busy_next = r_busy;
        if (w_accept) begin
            w_busy_next[w_dest] = 1'b0;
        end
        if (issue_en) begin
            w_busy_next[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_ptr       <= 1'b0;
            r_busy      <= '0;
            r_rf_dest   <= '0;
            r_rf_w_in   <= '0;
            r_rf_w_en   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rf_w_en <= 1'b1;
                    r_rf_dest <= r_cnt;
                    r_rf_w_in <= '0;
                    r_busy    <= '0;
                    r_cnt     <= r_cnt + AW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_rf_w_en <= w_accept;
                    if (w_accept) begin
                        r_rf_dest <= w_dest;
                        r_rf_w_in <= w_data;
                        r_ptr     <= w_grant_a;
                    end
                    r_busy <= w_busy_next;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign busy      = r_busy;
    assign rf_dest   = r_rf_dest;
    assign rf_w_in   = r_rf_w_in;
    assign rf_w_en   = r_rf_w_en;
    assign init_done = r_init_done;

endmodule

`default_nettype wire
